// File: rtl/fifo_traffic_gen_if.sv
// rtl/fifo_traffic_gen_if.sv - FIFO handshake bundle between traffic generator and FIFO under test
`ifndef FIFO_DWIDTH
`define FIFO_DWIDTH 8
`endif

interface fifo_traffic_gen_if #(
  parameter int WIDTH = `FIFO_DWIDTH
);
  logic             push;
  logic             pop;
  logic             start;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;

  modport master (output push, pop, start, data_out, input full, empty);
  modport slave  (input push, pop, start, data_out, output full, empty);
endinterface

// File: rtl/fifo_traffic_gen.sv
// rtl/fifo_traffic_gen.sv - constrained FIFO push/pop generator with magic-packet tracking (optional stall: FTG_STALL_EN)
`ifndef FIFO_DWIDTH
`define FIFO_DWIDTH 8
`endif
`ifndef FIFO_DEPTH
`define FIFO_DEPTH 8
`endif

module fifo_traffic_gen #(
  parameter int          WIDTH    = `FIFO_DWIDTH,
  parameter int          DEPTH    = `FIFO_DEPTH,
  parameter int          CNTWID   = $clog2(DEPTH) + 1,
  parameter int          NUM_PUSH = 16,
  parameter int          MAGIC_AT = 3,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
`ifdef FTG_STALL_EN
  input  logic              stall,
`endif
  fifo_traffic_gen_if.master fifo,
  output logic [WIDTH-1:0]  magic_data,
  output logic              magic_out,
  output logic [CNTWID-1:0] occupancy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [15:0]       LAST_PUSH = 16'(NUM_PUSH - 1);
  localparam logic [15:0]       MAGIC_IDX = 16'(MAGIC_AT);
  localparam logic [CNTWID-1:0] FULL_CNT  = CNTWID'(DEPTH);
  localparam logic [CNTWID-1:0] ONE       = CNTWID'(1);

  state_t            state;
  state_t            state_next;
  logic [15:0]       lfsr;
  logic [15:0]       push_cnt;
  logic [CNTWID-1:0] occ_next;
  logic [CNTWID-1:0] magic_pos;
  logic              magic_live;
  logic              stall_i;
  logic              push;
  logic              pop;
  logic              start;
  logic              advance;
  logic              lfsr_fb;

`ifdef FTG_STALL_EN
  assign stall_i = stall;
`else
  assign stall_i = 1'b0;
`endif

  assign fifo.push     = push;
  assign fifo.pop      = pop;
  assign fifo.start    = start;
  assign fifo.data_out = WIDTH'(push_cnt);

  // Taps 16,14,13,11 in 1-based numbering; shift toward the MSB.
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign advance = ((state == RUN) || (state == DRAIN)) && !stall_i;

  // Next state and handshake decode; full/empty gate push/pop unconditionally.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    pop        = 1'b0;
    start      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !stall_i) state_next = RUN;
      end
      RUN: begin
        push = lfsr[0] & ~fifo.full & ~stall_i;
        pop  = lfsr[1] & ~fifo.empty & ~stall_i;
        if (push && (push_cnt == LAST_PUSH)) state_next = DRAIN;
      end
      DRAIN: begin
        pop = ~fifo.empty & ~stall_i;
        if (!stall_i && (occupancy == '0) && !pop) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    start = push & (push_cnt == MAGIC_IDX) & ~magic_live;
  end

  // Occupancy model with defensive clamping at both ends.
  always_comb begin
    occ_next = occupancy;
    if (push && !pop && (occupancy != FULL_CNT))
      occ_next = occupancy + ONE;
    else if (pop && !push && (occupancy != '0))
      occ_next = occupancy - ONE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // LFSR steps only while active; push counter tracks issued pushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr     <= SEED;
      push_cnt <= '0;
    end else begin
      if (advance) lfsr <= {lfsr[14:0], lfsr_fb};
      if (push)    push_cnt <= push_cnt + 16'd1;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) occupancy <= '0;
    else     occupancy <= occ_next;
  end

  // Magic packet: capture on injection, count entries ahead down on each pop, pulse when it leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      magic_pos  <= '0;
      magic_live <= 1'b0;
      magic_data <= '0;
      magic_out  <= 1'b0;
    end else begin
      magic_out <= 1'b0;
      if (start) begin
        magic_data <= fifo.data_out;
        magic_live <= 1'b1;
        magic_pos  <= (pop && (occupancy != '0)) ? occupancy - ONE : occupancy;
      end else if (magic_live && pop) begin
        if (magic_pos == '0) begin
          magic_out  <= 1'b1;
          magic_live <= 1'b0;
        end else begin
          magic_pos <= magic_pos - ONE;
        end
      end
    end
  end

`ifdef FORMAL
  // External full/empty must agree with the modelled count; a disagreement is a harness error.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo.full && (occupancy != FULL_CNT)));
      assert (!(fifo.empty && (occupancy != '0)));
    end
  end
`endif

endmodule

// File: tb/tb_fifo_traffic_gen.sv
// tb/tb_fifo_traffic_gen.sv - directed self-checking bench for fifo_traffic_gen
module tb_fifo_traffic_gen;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int NP = 16;
  localparam int MA = 3;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic enable4 = 1'b0;
  logic stall = 1'b0;
  int   checks = 0;
  int   failures = 0;

  fifo_traffic_gen_if #(.WIDTH(W)) u_if ();
  fifo_traffic_gen_if #(.WIDTH(W)) u_if4 ();

  logic [W-1:0] magic_data, magic_data4;
  logic         magic_out, magic_out4;
  logic [3:0]   occupancy;
  logic [2:0]   occupancy4;
  logic         done, done4;

  fifo_traffic_gen #(.WIDTH(W), .DEPTH(D), .NUM_PUSH(NP), .MAGIC_AT(MA), .SEED(16'hACE1)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
`ifdef FTG_STALL_EN
    .stall      (stall),
`endif
    .fifo       (u_if.master),
    .magic_data (magic_data),
    .magic_out  (magic_out),
    .occupancy  (occupancy),
    .done       (done)
  );

  fifo_traffic_gen #(.WIDTH(W), .DEPTH(4), .NUM_PUSH(NP), .MAGIC_AT(MA), .SEED(16'hACE1)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable4),
`ifdef FTG_STALL_EN
    .stall      (1'b0),
`endif
    .fifo       (u_if4.master),
    .magic_data (magic_data4),
    .magic_out  (magic_out4),
    .occupancy  (occupancy4),
    .done       (done4)
  );

  always #5 clk = ~clk;

  // Reference model of the main instance: LFSR, state, push index and a tagged FIFO queue.
  logic [1:0]  m_state;
  logic [15:0] m_lfsr;
  logic [15:0] m_pcnt;
  logic [8:0]  q[$];
  logic        e_magic_out;
  logic [7:0]  mg_pop_data;
  logic        mp, mo, madv;
  logic [8:0]  ment;
  logic        stall_i;
  logic        e_push, e_pop, e_start;

  assign stall_i = stall;
  assign e_push  = (m_state == S_RUN) && m_lfsr[0] && !u_if.full && !stall_i;
  assign e_pop   = (((m_state == S_RUN) && m_lfsr[1]) || (m_state == S_DRAIN)) && !u_if.empty && !stall_i;
  assign e_start = e_push && (m_pcnt == 16'(MA));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = S_IDLE;
      m_lfsr = 16'hACE1;
      m_pcnt = 16'd0;
      q.delete();
      e_magic_out = 1'b0;
      mg_pop_data = 8'd0;
    end else begin
      mp = e_push;
      mo = e_pop;
      madv = ((m_state == S_RUN) || (m_state == S_DRAIN)) && !stall_i;
      e_magic_out = 1'b0;
      if (mo && (q.size() > 0)) begin
        ment = q.pop_front();
        if (ment[8]) begin
          e_magic_out = 1'b1;
          mg_pop_data = ment[7:0];
        end
      end
      case (m_state)
        S_IDLE:  if (enable && !stall_i) m_state = S_RUN;
        S_RUN:   if (mp && (m_pcnt == 16'(NP - 1))) m_state = S_DRAIN;
        S_DRAIN: if (!stall_i && (q.size() == 0) && !mp && !mo) m_state = S_DONE;
        default: ;
      endcase
      if (mp) begin
        q.push_back({m_pcnt == 16'(MA), u_if.data_out});
        m_pcnt = m_pcnt + 16'd1;
      end
      if (madv) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  int run_push, run_pop;

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    enable4 = 1'b0;
    stall = 1'b0;
    u_if.full = 1'b0;
    u_if.empty = 1'b1;
    u_if4.full = 1'b0;
    u_if4.empty = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      checks += 5;
      if (u_if.push !== 1'b0) begin failures++; $display("FAIL reset_push: got %b expected 0", u_if.push); end
      if (u_if.pop !== 1'b0) begin failures++; $display("FAIL reset_pop: got %b expected 0", u_if.pop); end
      if (occupancy !== 4'd0) begin failures++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
      if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
      if (magic_out !== 1'b0) begin failures++; $display("FAIL reset_magic_out: got %b expected 0", magic_out); end
    end
    checks++;
    if (magic_data !== 8'h00) begin failures++; $display("FAIL reset_magic_data: got %0h expected 0", magic_data); end
  endtask

  task automatic test_backpressure();
    int pushes4;
    int starts4;
    do_reset();
    pushes4 = 0;
    starts4 = 0;
    @(negedge clk);
    enable4 = 1'b1;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      u_if4.full = (pushes4 >= 4);
      u_if4.empty = 1'b1;
      #1;
      if (u_if4.full) begin
        checks++;
        if (u_if4.push !== 1'b0) begin failures++; $display("FAIL bp_push_while_full: got %b expected 0 cycle %0d", u_if4.push, c); end
      end
      checks += 2;
      if (u_if4.pop !== 1'b0) begin failures++; $display("FAIL bp_pop_while_empty: got %b expected 0", u_if4.pop); end
      if (magic_out4 !== 1'b0) begin failures++; $display("FAIL bp_magic_out: got %b expected 0", magic_out4); end
      if (u_if4.push === 1'b1) pushes4++;
      if (u_if4.start === 1'b1) starts4++;
    end
    checks += 5;
    if (pushes4 != 4) begin failures++; $display("FAIL bp_push_count: got %0d expected 4", pushes4); end
    if (occupancy4 !== 3'd4) begin failures++; $display("FAIL bp_occupancy: got %0d expected 4", occupancy4); end
    if (magic_data4 !== 8'h03) begin failures++; $display("FAIL bp_magic_data: got %0h expected 03", magic_data4); end
    if (starts4 != 1) begin failures++; $display("FAIL bp_start_count: got %0d expected 1", starts4); end
    if (done4 !== 1'b0) begin failures++; $display("FAIL bp_done: got %b expected 0", done4); end
    enable4 = 1'b0;
  endtask

  task automatic test_magic_tracking();
    int  n_pulse;
    logic prev_pop;
    logic finished;
    do_reset();
    run_push = 0;
    run_pop = 0;
    n_pulse = 0;
    prev_pop = 1'b0;
    finished = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    for (int c = 0; c < 3000 && !finished; c++) begin
      @(negedge clk);
      u_if.full = (q.size() == D);
      u_if.empty = (q.size() == 0);
      #1;
      checks += 5;
      if (u_if.push !== e_push) begin failures++; $display("FAIL mt_push: got %b expected %b cycle %0d", u_if.push, e_push, c); end
      if (u_if.pop !== e_pop) begin failures++; $display("FAIL mt_pop: got %b expected %b cycle %0d", u_if.pop, e_pop, c); end
      if (u_if.start !== e_start) begin failures++; $display("FAIL mt_start: got %b expected %b cycle %0d", u_if.start, e_start, c); end
      if (occupancy !== 4'(q.size())) begin failures++; $display("FAIL mt_occupancy: got %0d expected %0d", occupancy, q.size()); end
      if (magic_out !== e_magic_out) begin failures++; $display("FAIL mt_magic_out: got %b expected %b cycle %0d", magic_out, e_magic_out, c); end
      if (u_if.push === 1'b1) begin
        checks++;
        if (u_if.data_out !== m_pcnt[7:0]) begin failures++; $display("FAIL mt_data_out: got %0h expected %0h", u_if.data_out, m_pcnt[7:0]); end
      end
      if (magic_out === 1'b1) begin
        n_pulse++;
        checks++;
        if (!(prev_pop && (run_pop == 4))) begin failures++; $display("FAIL mt_pulse_timing: got pops=%0d prev_pop=%b expected pops=4 prev_pop=1", run_pop, prev_pop); end
      end
      if (u_if.push === 1'b1) run_push++;
      if (u_if.pop === 1'b1) run_pop++;
      prev_pop = u_if.pop;
      if (done === 1'b1) finished = 1'b1;
    end
    checks += 4;
    if (!finished) begin failures++; $display("FAIL mt_timeout: got done=0 expected done=1 within 3000 cycles"); end
    if (magic_data !== 8'h03) begin failures++; $display("FAIL mt_magic_data: got %0h expected 03", magic_data); end
    if (n_pulse != 1) begin failures++; $display("FAIL mt_pulse_count: got %0d expected 1", n_pulse); end
    if (mg_pop_data !== 8'h03) begin failures++; $display("FAIL mt_popped_magic: got %0h expected 03", mg_pop_data); end
  endtask

  task automatic test_drain_done();
    checks += 4;
    if (run_push != 16) begin failures++; $display("FAIL dd_push_count: got %0d expected 16", run_push); end
    if (run_pop != 16) begin failures++; $display("FAIL dd_pop_count: got %0d expected 16", run_pop); end
    if (done !== 1'b1) begin failures++; $display("FAIL dd_done: got %b expected 1", done); end
    if (occupancy !== 4'd0) begin failures++; $display("FAIL dd_occupancy: got %0d expected 0", occupancy); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      u_if.full = 1'b0;
      u_if.empty = (c < 5);
      #1;
      checks += 3;
      if (u_if.push !== 1'b0) begin failures++; $display("FAIL dd_push_after: got %b expected 0", u_if.push); end
      if (u_if.pop !== 1'b0) begin failures++; $display("FAIL dd_pop_after: got %b expected 0", u_if.pop); end
      if (done !== 1'b1) begin failures++; $display("FAIL dd_done_sticky: got %b expected 1", done); end
    end
  endtask

  task automatic test_simul_push_pop();
    int   npop;
    int   pops_after;
    int   n_pulse;
    logic mg_seen;
    logic prev_pop;
    logic finished;
    logic both;
    do_reset();
    npop = 0;
    pops_after = 0;
    n_pulse = 0;
    mg_seen = 1'b0;
    prev_pop = 1'b0;
    finished = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    for (int c = 0; c < 3000 && !finished; c++) begin
      @(negedge clk);
      if (m_pcnt < 16'(MA)) begin
        u_if.full = 1'b0;
        u_if.empty = 1'b1;
      end else if ((m_pcnt == 16'(MA)) && (npop == 0)) begin
        u_if.full = 1'b1;
        u_if.empty = (q.size() == 0);
      end else if (m_pcnt == 16'(MA)) begin
        both = (m_state == S_RUN) && (m_lfsr[1:0] == 2'b11);
        u_if.full = !both;
        u_if.empty = !both;
      end else begin
        u_if.full = (q.size() == D);
        u_if.empty = (q.size() == 0);
      end
      #1;
      checks += 4;
      if (u_if.push !== e_push) begin failures++; $display("FAIL sp_push: got %b expected %b cycle %0d", u_if.push, e_push, c); end
      if (u_if.pop !== e_pop) begin failures++; $display("FAIL sp_pop: got %b expected %b cycle %0d", u_if.pop, e_pop, c); end
      if (u_if.start !== e_start) begin failures++; $display("FAIL sp_start: got %b expected %b cycle %0d", u_if.start, e_start, c); end
      if (magic_out !== e_magic_out) begin failures++; $display("FAIL sp_magic_out: got %b expected %b cycle %0d", magic_out, e_magic_out, c); end
      if (magic_out === 1'b1) begin
        n_pulse++;
        checks++;
        if (!(prev_pop && (pops_after == 2))) begin failures++; $display("FAIL sp_pulse_timing: got pops_after=%0d prev_pop=%b expected 2 and 1", pops_after, prev_pop); end
      end
      if (u_if.start === 1'b1) begin
        mg_seen = 1'b1;
        checks += 2;
        if (u_if.pop !== 1'b1) begin failures++; $display("FAIL sp_pop_at_magic: got %b expected 1", u_if.pop); end
        if (occupancy !== 4'd2) begin failures++; $display("FAIL sp_occ_at_magic: got %0d expected 2", occupancy); end
      end else if (mg_seen && (n_pulse == 0) && (u_if.pop === 1'b1)) begin
        pops_after++;
      end
      if (u_if.pop === 1'b1) npop++;
      prev_pop = u_if.pop;
      if (done === 1'b1) finished = 1'b1;
    end
    checks += 4;
    if (!finished) begin failures++; $display("FAIL sp_timeout: got done=0 expected done=1 within 3000 cycles"); end
    if (!mg_seen) begin failures++; $display("FAIL sp_magic_push: got 0 expected 1 coincident magic push"); end
    if (n_pulse != 1) begin failures++; $display("FAIL sp_pulse_count: got %0d expected 1", n_pulse); end
    if (magic_data !== 8'h03) begin failures++; $display("FAIL sp_magic_data: got %0h expected 03", magic_data); end
  endtask

`ifdef FTG_STALL_EN
  task automatic test_stall();
    logic [7:0] saved;
    logic       finished;
    int         stalled;
    do_reset();
    finished = 1'b0;
    stalled = 0;
    saved = 8'd0;
    @(negedge clk);
    enable = 1'b1;
    for (int c = 0; c < 3000 && !finished; c++) begin
      @(negedge clk);
      u_if.full = (q.size() == D);
      u_if.empty = (q.size() == 0);
      if ((stalled == 0) && (m_pcnt >= 16'd5)) saved = m_pcnt[7:0];
      if ((m_pcnt >= 16'd5) && (stalled < 5)) begin
        stall = 1'b1;
        stalled++;
      end else begin
        stall = 1'b0;
      end
      #1;
      checks += 2;
      if (u_if.push !== e_push) begin failures++; $display("FAIL st_push: got %b expected %b cycle %0d", u_if.push, e_push, c); end
      if (u_if.pop !== e_pop) begin failures++; $display("FAIL st_pop: got %b expected %b cycle %0d", u_if.pop, e_pop, c); end
      if (stall) begin
        checks += 4;
        if (u_if.push !== 1'b0) begin failures++; $display("FAIL st_push_stalled: got %b expected 0", u_if.push); end
        if (u_if.pop !== 1'b0) begin failures++; $display("FAIL st_pop_stalled: got %b expected 0", u_if.pop); end
        if (u_if.start !== 1'b0) begin failures++; $display("FAIL st_start_stalled: got %b expected 0", u_if.start); end
        if (u_if.data_out !== saved) begin failures++; $display("FAIL st_push_cnt_hold: got %0h expected %0h", u_if.data_out, saved); end
      end
      if (done === 1'b1) finished = 1'b1;
    end
    stall = 1'b0;
    checks += 2;
    if (!finished) begin failures++; $display("FAIL st_timeout: got done=0 expected done=1 within 3000 cycles"); end
    if (magic_data !== 8'h03) begin failures++; $display("FAIL st_magic_data: got %0h expected 03", magic_data); end
  endtask
`endif

  initial begin
    u_if.full = 1'b0;
    u_if.empty = 1'b1;
    u_if4.full = 1'b0;
    u_if4.empty = 1'b1;
    test_reset();
    test_backpressure();
    test_magic_tracking();
    test_drain_done();
    test_simul_push_pop();
`ifdef FTG_STALL_EN
    test_stall();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_traffic_gen.md
Name: fifo_traffic_gen

Overview:
- Stimulus-side counterpart to the FIFO scoreboard. It drives push, pop, start and data into the FIFO under test and never violates the full/empty rules.
- Injects exactly one magic packet per run and tracks its position through the FIFO. It pulses magic_out on the cycle that packet is popped.
- Used in simulation benches and as a constrained driver in formal harnesses in place of free push/pop inputs.

Parameters:
- WIDTH, 8 (`FIFO_DWIDTH): FIFO data width.
- DEPTH, 8 (`FIFO_DEPTH): FIFO depth; power of two, >= 2.
- CNTWID, $clog2(DEPTH)+1: occupancy and position counter width.
- NUM_PUSH, 16: total pushes per run; 1..65535.
- MAGIC_AT, 3: zero-based push index carrying the magic packet; must be < NUM_PUSH.
- SEED, 16'hACE1: LFSR reset value; nonzero.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  starts a run from IDLE
- full  in  1  FIFO full
- empty  in  1  FIFO empty
- push  out  1  FIFO push
- pop  out  1  FIFO pop
- start  out  1  high with the push carrying the magic packet
- data_out  out  WIDTH  FIFO write data
- magic_data  out  WIDTH  value of the injected magic packet
- magic_out  out  1  one-cycle pulse when the magic packet is popped
- occupancy  out  CNTWID  internal model of FIFO count
- done  out  1  run complete

Behaviour:
- Reset (async, rst=1) clears all registered state:
  - state=IDLE; lfsr=SEED; push_cnt=0; occupancy=0.
  - magic_pos=0; magic_live=0; magic_data=0; magic_out=0; done=0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle in RUN and DRAIN and holds otherwise.
- States:
  - IDLE -> RUN when enable=1.
  - RUN -> DRAIN on the cycle the push with push_cnt==NUM_PUSH-1 is issued.
  - DRAIN -> DONE when occupancy==0 and no push/pop occurs this cycle.
  - DONE is sticky until reset; done=1 only in DONE.
- push (combinational) = (state==RUN) & lfsr[0] & ~full.
- pop (combinational) = ((state==RUN) & lfsr[1] | (state==DRAIN)) & ~empty.
- With full=1 or empty=1, the corresponding output is 0 in the same cycle, with no exceptions.
- data_out (combinational) = push_cnt[WIDTH-1:0]. It is valid only when push=1.
- push_cnt increments by 1 on each push and is 16 bits wide. It does not wrap within a run.
- start = push & (push_cnt==MAGIC_AT) & ~magic_live. On this cycle:
  - magic_data <= data_out; magic_live <= 1.
  - magic_pos <= occupancy - pop, i.e. the number of entries ahead of the magic packet after this cycle's pop.
- While magic_live:
  - Each pop with magic_pos!=0 decrements magic_pos.
  - A pop with magic_pos==0 sets magic_out<=1 for one cycle and clears magic_live.
  - magic_out is a registered pulse, so it appears one cycle after the pop edge.
- No pop can coincide with the magic push from an empty FIFO, because pop is gated by ~empty.
- occupancy <= occupancy + push - pop. It saturates at DEPTH and 0 as defensive clamping.
- If occupancy disagrees with full/empty (full=1 with occupancy!=DEPTH), that is a bench error. Simulation asserts it under `FORMAL; the RTL ignores it.
- Reset asserted mid-run returns to IDLE next edge-independently. No partial magic state survives.

Optional Feature:
- Macro: FTG_STALL_EN.
- Defined:
  - Adds input port stall (1 bit).
  - While stall=1, push=0, pop=0, start=0, and the LFSR, push_cnt and state hold.
  - magic_out still completes a pulse already registered.
- Undefined: no stall port; behaviour as above.

Test Plan:
- Reset: rst=1 for 2 cycles then 0, enable=0 -> push=0, pop=0, occupancy=0, done=0, state stays IDLE for 10 cycles.
- Full backpressure: DEPTH=4, full tied 1 after 4 pushes, enable=1 -> push never 1 while full=1; occupancy holds at 4.
- Magic tracking: MAGIC_AT=3, FIFO model attached, run to DONE -> magic_data==8'h03; magic_out pulses exactly once, one cycle after the 4th pop; the popped data equals 8'h03.
- Simultaneous push/pop at magic: force occupancy=2 with pop=1 on the magic push -> magic_pos=1; magic_out pulses after the second subsequent pop.
- Drain/done: NUM_PUSH=16 -> exactly 16 pushes and 16 pops; done=1 and occupancy==0; push/pop stay 0 afterwards.
- Stall (FTG_STALL_EN): stall=1 for 5 cycles mid-RUN -> push/pop=0, lfsr and push_cnt unchanged; resume produces the identical sequence to the unstalled run, shifted 5 cycles.
